// File: rtl/sram_bist_pkg.sv
// sram_bist shared types: FSM states, pattern modes
// and default SRAM geometry.
package sram_bist_pkg;

  localparam int ADDR_W_DEF = 19;
  localparam int DATA_W_DEF = 16;
  localparam int MODE_W     = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DONE
  } state_e;

  typedef enum logic [MODE_W-1:0] {
    MODE_ADDR  = 2'd0,
    MODE_INV   = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_WALK  = 2'd3
  } mode_e;

endpackage

// File: rtl/sram_bist_pattern.sv
// Combinational test pattern for a given mode and
// address, sized to the SRAM data width.
module sram_bist_pattern
  import sram_bist_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  mode_e             mode,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] pattern
);

  localparam logic [ADDR_W-1:0] DW =
    ADDR_W'(DATA_W);

  logic [DATA_W-1:0] lsb;
  logic [DATA_W-1:0] chk;
  logic [ADDR_W-1:0] shamt;

  always_comb begin
    lsb   = DATA_W'(addr);
    shamt = addr % DW;
    chk   = '0;
    // even addr -> ...0101, odd addr -> ...1010
    for (int i = 0; i < DATA_W; i++) begin
      chk[i] = (i % 2 == 0) ^ addr[0];
    end
    pattern = '0;
    unique case (mode)
      MODE_ADDR:  pattern = lsb;
      MODE_INV:   pattern = ~lsb;
      MODE_CHECK: pattern = chk;
      MODE_WALK:  pattern = DATA_W'(1) << shamt;
    endcase
  end

endmodule

// File: rtl/sram_bist.sv
// SRAM BIST engine: fills 0..ADDR_LAST with a pattern,
// reads it back and reports errors.
module sram_bist
  import sram_bist_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] ADDR_LAST =
    ADDR_W'('h0FFFF),
  parameter int ERR_W = 16
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ack,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  state_e            state;
  mode_e             mode_q;
  mode_e             pat_mode;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] pat_addr;
  logic [DATA_W-1:0] pat;
  logic [DATA_W-1:0] exp_q;
  logic [ERR_W-1:0]  err_nxt;
  logic              idle_ish;
  logic              at_last;
  logic              step;
  logic              miss;

  // The shared pattern unit always looks one word
  // ahead so write data and expected data register.
  always_comb begin
    idle_ish = (state == ST_IDLE) ||
               (state == ST_DONE);
    at_last  = (addr == ADDR_LAST);
    step     = (state == ST_WRITE && wr_ack) ||
               (state == ST_READ && rd_valid);
    addr_inc = at_last ? '0 : addr + 1'b1;
    pat_addr = step ? addr_inc :
               (idle_ish ? '0 : addr);
    pat_mode = idle_ish ? mode_e'(mode) : mode_q;
    miss     = (rd_data != exp_q);
    err_nxt  = err_count;
    if (miss && !(&err_count))
      err_nxt = err_count + 1'b1;
  end

  sram_bist_pattern #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_pattern (
    .mode    (pat_mode),
    .addr    (pat_addr),
    .pattern (pat)
  );

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      mode_q         <= MODE_ADDR;
      addr           <= '0;
      exp_q          <= '0;
      wr_req         <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      rd_req         <= 1'b0;
      rd_addr        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state          <= ST_WRITE;
            mode_q         <= mode_e'(mode);
            addr           <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            busy           <= 1'b1;
            wr_req         <= 1'b1;
            wr_addr        <= '0;
            wr_data        <= pat;
          end
        end
        ST_WRITE: begin
          if (wr_ack) begin
            addr <= addr_inc;
            if (at_last) begin
              state   <= ST_READ;
              wr_req  <= 1'b0;
              wr_addr <= '0;
              wr_data <= '0;
              rd_req  <= 1'b1;
              rd_addr <= '0;
              exp_q   <= pat;
            end else begin
              wr_addr <= addr_inc;
              wr_data <= pat;
            end
          end
        end
        ST_READ: begin
          if (rd_valid) begin
            addr      <= addr_inc;
            err_count <= err_nxt;
            if (miss && err_count == '0)
              first_err_addr <= addr;
            if (at_last) begin
              state   <= ST_DONE;
              rd_req  <= 1'b0;
              rd_addr <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (err_nxt == '0);
            end else begin
              rd_addr <= addr_inc;
              exp_q   <= pat;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bist.sv
// Directed bench for sram_bist with a 16-word
// memory model, variable ack latency and fault hooks.
module tb_sram_bist;

  localparam int AW = 19;
  localparam int DW = 16;
  localparam logic [AW-1:0] LAST = 19'd15;

  logic          clk_50m = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          wr_req, rd_req;
  logic [AW-1:0] wr_addr, rd_addr, first_err_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data = 16'hBEEF;
  logic          wr_ack = 1'b0, rd_valid = 1'b0;
  logic          busy, done, pass;
  logic [15:0]   err_count;

  logic          start2 = 1'b0;
  logic [1:0]    mode2 = 2'd1;
  logic          wr_req2, rd_req2;
  logic [AW-1:0] wr_addr2, rd_addr2, first2;
  logic [DW-1:0] wr_data2;
  logic [DW-1:0] rd_data2 = 16'h0000;
  logic          wr_ack2 = 1'b1, rd_valid2 = 1'b1;
  logic          busy2, done2, pass2;
  logic [1:0]    err2;

  int n_chk = 0;
  int n_fail = 0;

  always #10 clk_50m = ~clk_50m;

  sram_bist #(
    .ADDR_W(AW), .DATA_W(DW),
    .ADDR_LAST(LAST), .ERR_W(16)
  ) dut (
    .clk_50m(clk_50m), .rst_n(rst_n),
    .start(start), .mode(mode),
    .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count),
    .first_err_addr(first_err_addr)
  );

  sram_bist #(
    .ADDR_W(AW), .DATA_W(DW),
    .ADDR_LAST(LAST), .ERR_W(2)
  ) dut2 (
    .clk_50m(clk_50m), .rst_n(rst_n),
    .start(start2), .mode(mode2),
    .wr_req(wr_req2), .wr_addr(wr_addr2),
    .wr_data(wr_data2), .wr_ack(wr_ack2),
    .rd_req(rd_req2), .rd_addr(rd_addr2),
    .rd_data(rd_data2), .rd_valid(rd_valid2),
    .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2),
    .first_err_addr(first2)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // memory model, responds on the falling edge
  logic [15:0] mem [16];
  int          held [16];
  int          lat = 0;
  logic [15:0] corrupt = 16'h0000;
  int          wcnt = 0, rcnt = 0, viol = 0;
  logic        wpend = 1'b0, rpend = 1'b0;
  logic [AW-1:0] pa, pr;
  logic [DW-1:0] pd;

  always @(negedge clk_50m) begin
    if (!rst_n) begin
      wpend = 1'b0;
      rpend = 1'b0;
    end
    if (wr_req && rd_req) viol++;
    if (wpend && (wr_addr != pa || wr_data != pd))
      viol++;
    if (rpend && rd_addr != pr) viol++;
    wpend    = 1'b0;
    rpend    = 1'b0;
    wr_ack   = 1'b0;
    rd_valid = 1'b0;
    rd_data  = 16'hBEEF;
    if (wr_req) begin
      held[wr_addr[3:0]]++;
      if (wcnt == lat) begin
        wr_ack = 1'b1;
        mem[wr_addr[3:0]] = wr_data;
        wcnt = 0;
      end else begin
        wcnt++;
        wpend = 1'b1;
        pa = wr_addr;
        pd = wr_data;
      end
    end else wcnt = 0;
    if (rd_req) begin
      if (rcnt == lat) begin
        rd_valid = 1'b1;
        rd_data = mem[rd_addr[3:0]] ^
          {15'd0, corrupt[rd_addr[3:0]]};
        rcnt = 0;
      end else begin
        rcnt++;
        rpend = 1'b1;
        pr = rd_addr;
      end
    end else rcnt = 0;
  end

  task automatic clr();
    for (int i = 0; i < 16; i++) begin
      mem[i] = 16'hDEAD;
      held[i] = 0;
    end
  endtask

  task automatic run(
    input  logic [1:0] m,
    input  int         rs_at,
    input  int         msw_at,
    output int         dcyc
  );
    clr();
    @(negedge clk_50m);
    mode = m;
    start = 1'b1;
    @(negedge clk_50m);
    start = 1'b0;
    dcyc = -1;
    check("busy_c1", 32'(busy), 32'd1);
    for (int c = 1; c <= 400; c++) begin
      start = (c == rs_at);
      if (c == msw_at) mode = 2'd1;
      if (done) begin
        dcyc = c;
        break;
      end
      @(negedge clk_50m);
    end
    start = 1'b0;
  endtask

  int dc, bad, found;

  initial begin
    repeat (3) @(negedge clk_50m);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_outs", 32'(|{wr_req, wr_addr,
      wr_data, rd_req, rd_addr, pass,
      err_count, first_err_addr}), 32'd0);
    check("rst2_outs", 32'(|{wr_req2, wr_addr2,
      wr_data2, rd_req2, rd_addr2, busy2, done2,
      pass2, err2, first2}), 32'd0);
    rst_n = 1'b1;

    run(2'd0, 0, 0, dc);
    check("t1_done_cyc", 32'(dc), 32'd33);
    check("t1_wr5", 32'(mem[5]), 32'h0005);
    check("t1_pass", 32'(pass), 32'd1);
    check("t1_err", 32'(err_count), 32'd0);
    repeat (3) @(negedge clk_50m);
    check("t1_done_hold", 32'(done), 32'd1);

    lat = 2;
    run(2'd2, 0, 0, dc);
    check("t2_done_cyc", 32'(dc), 32'd97);
    bad = 0;
    for (int a = 0; a < 16; a++) begin
      if (held[a] != 3) bad++;
      if (mem[a] != ((a % 2) ? 16'hAAAA : 16'h5555))
        bad++;
    end
    check("t2_hold_alt", 32'(bad), 32'd0);
    check("t2_wr1", 32'(mem[1]), 32'hAAAA);
    check("t2_pass", 32'(pass), 32'd1);
    lat = 0;

    corrupt = 16'h0208;
    run(2'd3, 0, 0, dc);
    check("t3_done_cyc", 32'(dc), 32'd33);
    check("t3_wr9", 32'(mem[9]), 32'h0200);
    check("t3_err", 32'(err_count), 32'd2);
    check("t3_first", 32'(first_err_addr), 32'd3);
    check("t3_pass", 32'(pass), 32'd0);

    corrupt = 16'h8000;
    run(2'd0, 0, 0, dc);
    check("t4_done_cyc", 32'(dc), 32'd33);
    check("t4_err", 32'(err_count), 32'd1);
    check("t4_first", 32'(first_err_addr), 32'd15);
    check("t4_pass", 32'(pass), 32'd0);
    corrupt = 16'h0000;

    @(negedge clk_50m);
    start2 = 1'b1;
    @(negedge clk_50m);
    start2 = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (done2) break;
      @(negedge clk_50m);
    end
    check("t5_done", 32'(done2), 32'd1);
    check("t5_err_sat", 32'(err2), 32'd3);
    check("t5_first", 32'(first2), 32'd0);
    check("t5_pass", 32'(pass2), 32'd0);

    clr();
    @(negedge clk_50m);
    mode = 2'd0;
    start = 1'b1;
    @(negedge clk_50m);
    start = 1'b0;
    found = 0;
    for (int c = 1; c <= 200; c++) begin
      if (rd_req && rd_addr == 19'd7) begin
        found = 1;
        break;
      end
      @(negedge clk_50m);
    end
    check("t6_reach7", 32'(found), 32'd1);
    #1 rst_n = 1'b0;
    @(negedge clk_50m);
    check("t6_rst_outs", 32'(|{wr_req, wr_addr,
      wr_data, rd_req, rd_addr, busy, done, pass,
      err_count, first_err_addr}), 32'd0);
    #1 rst_n = 1'b1;
    run(2'd0, 0, 0, dc);
    check("t6_rerun_cyc", 32'(dc), 32'd33);
    check("t6_rerun_pass", 32'(pass), 32'd1);

    run(2'd0, 5, 0, dc);
    check("t7_done_cyc", 32'(dc), 32'd33);
    check("t7_pass", 32'(pass), 32'd1);

    run(2'd0, 0, 4, dc);
    bad = 0;
    for (int a = 0; a < 16; a++)
      if (mem[a] != 16'(a)) bad++;
    check("t8_mode0_data", 32'(bad), 32'd0);
    check("t8_pass", 32'(pass), 32'd1);
    mode = 2'd0;

    check("hs_viol", 32'(viol), 32'd0);
    $display(
      "End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
